keypad_entry_ctrl: RTL and testbench

Sequencing controller for the 4x3 `keypad` scanner in the ATM coin machine. It asserts `start` to run scans and waits for `dataReady`. It decodes `foundRow`/`foundCol` into keys and enforces one event per physical press. Digits are accumulated into a decimal entry (PIN or amount), and the completed value is handed to the processor on a valid/ack handshake.

---
 rtl/keypad_entry_ctrl_pkg.sv | 25 ++
 rtl/keypad_entry_ctrl_decode.sv | 42 ++++
 rtl/keypad_entry_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: FSM state encoding,
// key codes produced by the row/column decoder, and the decimal shift helper.
package keypad_entry_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_DECODE  = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    // Appends one decimal digit: v*10 + d, built from two shifts so no
    // multiplier is inferred; wraps modulo 2^32.
    function automatic logic [31:0] mul10_add(input logic [31:0] v, input logic [3:0] d);
        return (v << 3) + (v << 1) + {28'd0, d};
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_decode.sv
// Combinational keypad decoder: maps a (row, col) report from the scanner to a
// 4-bit key code. Out-of-range coordinates yield KEY_NONE with valid low.
module keypad_entry_ctrl_decode
    import keypad_entry_ctrl_pkg::*;
(
    input  logic [31:0] row_i,
    input  logic [31:0] col_i,
    output logic [3:0]  key_o,
    output logic        valid_o
);

    logic [3:0] row_s;
    logic [3:0] col_s;

    assign row_s = {2'b00, row_i[1:0]};
    assign col_s = {2'b00, col_i[1:0]};

    // Digit rows map to row*3+col+1; the bottom row holds *, 0 and #.
    always_comb begin
        key_o   = KEY_NONE;
        valid_o = 1'b0;
        if ((row_i < 32'd3) && (col_i < 32'd3)) begin
            key_o   = (row_s * 4'd3) + col_s + 4'd1;
            valid_o = 1'b1;
        end else if ((row_i == 32'd3) && (col_i < 32'd3)) begin
            valid_o = 1'b1;
            case (col_i[1:0])
                2'd0:    key_o = KEY_STAR;
                2'd1:    key_o = KEY_0;
                2'd2:    key_o = KEY_HASH;
                default: begin
                    key_o   = KEY_NONE;
                    valid_o = 1'b0;
                end
            endcase
        end else begin
            key_o   = KEY_NONE;
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: drives scans of the keypad scanner, synchronizes
// its dataReady strobe, accepts one key per physical press, accumulates a
// decimal entry and hands the finished value over on a valid/ack handshake.
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS     = 4,
    parameter int RELEASE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        start,
    input  logic        dataReady,
    input  logic [31:0] foundRow,
    input  logic [31:0] foundCol,
    output logic [31:0] value,
    output logic [3:0]  digit_count,
    output logic        key_event,
    output logic        overflow,
    output logic        entry_valid,
    input  logic        entry_ack
);

    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [REL_W-1:0] REL_LAST  = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       MAX_CNT   = 4'(MAX_DIGITS);

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]         key_q, key_d;
    logic               key_vld_q, key_vld_d;
    logic [31:0]        value_q, value_d;
    logic [3:0]         count_q, count_d;
    logic               pend_q, pend_d;
    logic               start_q, start_d;
    logic               key_event_q, key_event_d;
    logic               overflow_q, overflow_d;
    logic               entry_valid_q, entry_valid_d;

    logic               rise_s;
    logic               blip_s;
    logic [3:0]         dec_key_s;
    logic               dec_vld_s;

    keypad_entry_ctrl_decode u_decode (
        .row_i   (foundRow),
        .col_i   (foundCol),
        .key_o   (dec_key_s),
        .valid_o (dec_vld_s)
    );

    // Rising edge of the synchronized strobe starts a new key report.
    assign rise_s = sync2_q & ~prev_q;

    // Two-flop synchronizer for dataReady plus a delay flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= dataReady;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Next-state, counter, accumulator and output decisions for the entry FSM.
    always_comb begin
        state_d       = state_q;
        rel_cnt_d     = '0;
        tmo_cnt_d     = '0;
        key_d         = key_q;
        key_vld_d     = key_vld_q;
        value_d       = value_q;
        count_d       = count_q;
        pend_d        = pend_q;
        key_event_d   = 1'b0;
        overflow_d    = 1'b0;
        blip_s        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    value_d = 32'd0;
                    count_d = 4'd0;
                    pend_d  = 1'b0;
                end else if (rise_s) begin
                    state_d   = S_DECODE;
                    key_d     = dec_key_s;
                    key_vld_d = dec_vld_s;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    // Scanner went quiet: drop start for one cycle to re-trigger it.
                    blip_s    = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    value_d = 32'd0;
                    count_d = 4'd0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_RELEASE;
                    if (key_vld_q) begin
                        key_event_d = 1'b1;
                        if (key_q <= KEY_9) begin
                            if (count_q < MAX_CNT) begin
                                value_d = mul10_add(value_q, key_q);
                                count_d = count_q + 4'd1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else if (key_q == KEY_STAR) begin
                            value_d = 32'd0;
                            count_d = 4'd0;
                        end else if (key_q == KEY_HASH) begin
                            // An empty entry cannot be submitted.
                            if (count_q != 4'd0) begin
                                pend_d = 1'b1;
                            end else begin
                                pend_d = pend_q;
                            end
                        end else begin
                            value_d = value_q;
                        end
                    end else begin
                        key_event_d = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    value_d = 32'd0;
                    count_d = 4'd0;
                    pend_d  = 1'b0;
                end else if (sync2_q) begin
                    // Any bounce back high restarts the release window.
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == REL_LAST) begin
                    rel_cnt_d = '0;
                    state_d   = pend_q ? S_DONE : S_SCAN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            S_DONE: begin
                if (entry_ack) begin
                    value_d = 32'd0;
                    count_d = 4'd0;
                    pend_d  = 1'b0;
                    state_d = enable ? S_SCAN : S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                value_d = 32'd0;
                count_d = 4'd0;
                pend_d  = 1'b0;
            end
        endcase

        start_d       = (state_d == S_SCAN) && !blip_s;
        entry_valid_d = (state_d == S_DONE);
    end

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rel_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            key_q         <= KEY_NONE;
            key_vld_q     <= 1'b0;
            value_q       <= 32'd0;
            count_q       <= 4'd0;
            pend_q        <= 1'b0;
            start_q       <= 1'b0;
            key_event_q   <= 1'b0;
            overflow_q    <= 1'b0;
            entry_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rel_cnt_q     <= rel_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            key_q         <= key_d;
            key_vld_q     <= key_vld_d;
            value_q       <= value_d;
            count_q       <= count_d;
            pend_q        <= pend_d;
            start_q       <= start_d;
            key_event_q   <= key_event_d;
            overflow_q    <= overflow_d;
            entry_valid_q <= entry_valid_d;
        end
    end

    assign start       = start_q;
    assign value       = value_q;
    assign digit_count = count_q;
    assign key_event   = key_event_q;
    assign overflow    = overflow_q;
    assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed key tables, timing
// sequences for latency/bounce/timeout/reset, and random presses against a
// press-level reference model.
module tb_keypad_entry_ctrl;

    localparam int MAXD = 4;
    localparam int RELC = 16;
    localparam int TMOC = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        start;
    logic        dataReady = 1'b0;
    logic [31:0] foundRow = 32'd0;
    logic [31:0] foundCol = 32'd0;
    logic [31:0] value;
    logic [3:0]  digit_count;
    logic        key_event;
    logic        overflow;
    logic        entry_valid;
    logic        entry_ack = 1'b0;

    keypad_entry_ctrl #(
        .MAX_DIGITS     (MAXD),
        .RELEASE_CYCLES (RELC),
        .TIMEOUT_CYCLES (TMOC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .dataReady   (dataReady),
        .foundRow    (foundRow),
        .foundCol    (foundCol),
        .value       (value),
        .digit_count (digit_count),
        .key_event   (key_event),
        .overflow    (overflow),
        .entry_valid (entry_valid),
        .entry_ack   (entry_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int kev_cnt = 0;
    int ovf_cnt = 0;
    int last_kev_cyc = -1;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (key_event === 1'b1) begin
            kev_cnt++;
            last_kev_cyc = cyc;
        end
        if (overflow === 1'b1) ovf_cnt++;
    end

    typedef struct {
        int row;
        int col;
        int exp_value;
        int exp_count;
        int exp_kev;
        int exp_ovf;
        bit exp_valid;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic press(input int row, input int col, input int hold);
        @(negedge clock);
        foundRow  = row;
        foundCol  = col;
        dataReady = 1'b1;
        repeat (hold) @(negedge clock);
        dataReady = 1'b0;
        repeat (RELC + 8) @(negedge clock);
    endtask

    task automatic do_ack();
        @(negedge clock);
        entry_ack = 1'b1;
        @(negedge clock);
        entry_ack = 1'b0;
        check("ack_valid_low", {31'd0, entry_valid}, 32'd0);
        check("ack_value_clear", value, 32'd0);
        check("ack_count_clear", {28'd0, digit_count}, 32'd0);
        check("ack_back_to_scan", {31'd0, start}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start"}, {31'd0, start}, 32'd0);
        check({tag, "_value"}, value, 32'd0);
        check({tag, "_count"}, {28'd0, digit_count}, 32'd0);
        check({tag, "_kev"}, {31'd0, key_event}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        check({tag, "_valid"}, {31'd0, entry_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0, kv0, ov0, c, k, lows, first_low;
        int m_val, m_cnt, r, cl, e_kev, e_ovf;
        bit e_valid;

        // Directed entries: digits, submit, overflow, clear, empty submit, invalid.
        tbl[0]  = '{0, 0, 1,    1, 1, 0, 1'b0};
        tbl[1]  = '{0, 1, 12,   2, 1, 0, 1'b0};
        tbl[2]  = '{0, 2, 123,  3, 1, 0, 1'b0};
        tbl[3]  = '{1, 0, 1234, 4, 1, 0, 1'b0};
        tbl[4]  = '{3, 2, 1234, 4, 1, 0, 1'b1};
        tbl[5]  = '{0, 0, 1,    1, 1, 0, 1'b0};
        tbl[6]  = '{0, 1, 12,   2, 1, 0, 1'b0};
        tbl[7]  = '{0, 2, 123,  3, 1, 0, 1'b0};
        tbl[8]  = '{1, 0, 1234, 4, 1, 0, 1'b0};
        tbl[9]  = '{1, 1, 1234, 4, 1, 1, 1'b0};
        tbl[10] = '{3, 2, 1234, 4, 1, 0, 1'b1};
        tbl[11] = '{2, 0, 7,    1, 1, 0, 1'b0};
        tbl[12] = '{2, 1, 78,   2, 1, 0, 1'b0};
        tbl[13] = '{3, 0, 0,    0, 1, 0, 1'b0};
        tbl[14] = '{2, 2, 9,    1, 1, 0, 1'b0};
        tbl[15] = '{3, 2, 9,    1, 1, 0, 1'b1};
        tbl[16] = '{3, 2, 0,    0, 1, 0, 1'b0};
        tbl[17] = '{3, 3, 0,    0, 0, 0, 1'b0};

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Fresh SCAN entry; start must drop for exactly one cycle after the timeout.
        enable = 1'b1;
        c = cyc;
        lows = 0;
        first_low = -1;
        repeat (TMOC + 5) begin
            @(negedge clock);
            if (start !== 1'b1) begin
                lows++;
                if (first_low < 0) first_low = cyc;
            end
        end
        check("timeout_low_cycles", lows, 1);
        check("timeout_drop_cycle", first_low, c + 1 + TMOC + 1);

        // Table-driven presses.
        for (int i = 0; i < 18; i++) begin
            kv0 = kev_cnt;
            ov0 = ovf_cnt;
            press(tbl[i].row, tbl[i].col, 3 + (i % 4));
            check($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
            check($sformatf("tbl%0d_count", i), {28'd0, digit_count}, tbl[i].exp_count);
            check($sformatf("tbl%0d_kev", i), kev_cnt - kv0, tbl[i].exp_kev);
            check($sformatf("tbl%0d_ovf", i), ovf_cnt - ov0, tbl[i].exp_ovf);
            check($sformatf("tbl%0d_valid", i), {31'd0, entry_valid}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) do_ack();
        end
        check("empty_hash_stays_scan", {31'd0, start}, 32'd1);

        // Long hold with a short bounce: one key event, k+3 latency, start falls at k+2.
        kv0 = kev_cnt;
        @(negedge clock);
        foundRow  = 32'd2;
        foundCol  = 32'd0;
        dataReady = 1'b1;
        k = cyc + 1;
        repeat (50) begin
            @(negedge clock);
            if (cyc == k + 1) check("start_before_decode", {31'd0, start}, 32'd1);
            if (cyc == k + 2) check("start_at_decode", {31'd0, start}, 32'd0);
        end
        dataReady = 1'b0;
        repeat (5) @(negedge clock);
        dataReady = 1'b1;
        repeat (20) @(negedge clock);
        dataReady = 1'b0;
        repeat (RELC + 8) @(negedge clock);
        check("bounce_one_event", kev_cnt - kv0, 1);
        check("key_latency", last_kev_cyc, k + 3);
        check("bounce_value", value, 32'd7);
        check("bounce_back_in_scan", {31'd0, start}, 32'd1);

        // Clear, enter 56, then reset asynchronously mid-cycle.
        press(3, 0, 2);
        press(1, 1, 2);
        press(1, 2, 2);
        check("pre_reset_value", value, 32'd56);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Drop enable while scanning with a partial entry.
        press(1, 1, 2);
        press(1, 2, 2);
        check("pre_disable_value", value, 32'd56);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("disable_start", {31'd0, start}, 32'd0);
        check("disable_value", value, 32'd0);
        check("disable_count", {28'd0, digit_count}, 32'd0);
        enable = 1'b1;
        @(negedge clock);
        check("reenable_start", {31'd0, start}, 32'd1);

        // Random presses against a press-level model.
        m_val = 0;
        m_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 4);
            cl = $urandom_range(0, 3);
            e_kev = 0;
            e_ovf = 0;
            e_valid = 1'b0;
            if (r <= 2 && cl <= 2 || r == 3 && cl == 1) begin
                e_kev = 1;
                if (m_cnt < MAXD) begin
                    m_val = m_val * 10 + ((r == 3) ? 0 : r * 3 + cl + 1);
                    m_cnt++;
                end else begin
                    e_ovf = 1;
                end
            end else if (r == 3 && cl == 0) begin
                e_kev = 1;
                m_val = 0;
                m_cnt = 0;
            end else if (r == 3 && cl == 2) begin
                e_kev = 1;
                e_valid = (m_cnt > 0);
            end
            kv0 = kev_cnt;
            ov0 = ovf_cnt;
            press(r, cl, $urandom_range(1, 20));
            check($sformatf("rnd%0d_value", n), value, m_val);
            check($sformatf("rnd%0d_count", n), {28'd0, digit_count}, m_cnt);
            check($sformatf("rnd%0d_kev", n), kev_cnt - kv0, e_kev);
            check($sformatf("rnd%0d_ovf", n), ovf_cnt - ov0, e_ovf);
            check($sformatf("rnd%0d_valid", n), {31'd0, entry_valid}, {31'd0, e_valid});
            if (e_valid) begin
                do_ack();
                m_val = 0;
                m_cnt = 0;
            end
        end

        k0 = n_err;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, k0);
        $finish;
    end

endmodule
